// File: rtl/reset_pipe_synchronizer.sv
// rtl/reset_pipe_synchronizer.sv - chip-level reset synchronizer, asynchronous assert and clk-aligned release
module reset_pipe_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic async_in_rst,
    output logic sync_out_rst
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("reset_pipe_synchronizer: STAGES must be 2 or more");
        end
    endgenerate

    // Power-up value of 0 keeps downstream logic held until a real release has walked the chain.
    logic [STAGES-1:0] stage_q = '0;
    logic [STAGES-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge async_in_rst) begin
        if (!async_in_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_out_rst = stage_q[STAGES-1];

endmodule

// File: tb/tb_reset_pipe_synchronizer.sv
// tb/tb_reset_pipe_synchronizer.sv - self-checking bench for reset_pipe_synchronizer
module tb_reset_pipe_synchronizer;

    localparam int STAGES = 2;

    typedef struct {
        logic rst;
        logic exp_out;
    } vec_t;

    logic clk          = 1'b0;
    logic async_in_rst = 1'b1;
    logic sync_out_rst;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    vec_t vec_q[$];

    reset_pipe_synchronizer #(.STAGES(STAGES)) dut (
        .clk          (clk),
        .async_in_rst (async_in_rst),
        .sync_out_rst (sync_out_rst)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %b required test completion", sync_out_rst);
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input logic v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string nm);
        logic e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b required an expected value", nm, sync_out_rst);
            return;
        end
        e = exp_q.pop_front();
        if (sync_out_rst !== e) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, sync_out_rst, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic e);
        vec_t v;
        v.rst     = r;
        v.exp_out = e;
        vec_q.push_back(v);
    endtask

    initial begin
        // table: rst driven 1 ns after a posedge, output expected 1 ns after the next posedge
        for (int i = 0; i < 5; i++) begin
            add_vec(1'b0, 1'b0);
            add_vec(1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0);
        add_vec(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b1);
        add_vec(1'b0, 1'b0);
        add_vec(1'b1, 1'b0);
        add_vec(1'b1, 1'b1);
        add_vec(1'b1, 1'b1);

        // power-up: never driven low, output held 0 until the chain fills
        #1;
        expect_val(1'b0);
        compare("powerup_t0");
        tick();
        expect_val(1'b0);
        compare("powerup_edge1");
        tick();
        expect_val(1'b1);
        compare("powerup_edge2");

        // mid-period assertion with no clock edge, then long hold low
        #3;
        async_in_rst = 1'b0;
        #1;
        expect_val(1'b0);
        compare("async_assert");
        repeat (10) tick();
        expect_val(1'b0);
        compare("held_low_10");
        repeat (15) tick();
        expect_val(1'b0);
        compare("held_low_25");

        // precise release 1 ns after a posedge
        async_in_rst = 1'b1;
        tick();
        expect_val(1'b0);
        compare("release_edge1");
        tick();
        expect_val(1'b1);
        compare("release_edge2");
        repeat (20) tick();
        expect_val(1'b1);
        compare("release_hold20");

        // abort a release that is half way through the chain
        async_in_rst = 1'b0;
        tick();
        async_in_rst = 1'b1;
        tick();
        expect_val(1'b0);
        compare("abort_partial");
        #1;
        async_in_rst = 1'b0;
        #1;
        expect_val(1'b0);
        compare("abort_assert");
        async_in_rst = 1'b1;
        repeat (3) tick();
        expect_val(1'b1);
        compare("abort_recover");

        // rapid toggle on clock edges: release edge may or may not count
        @(posedge clk);
        async_in_rst = 1'b0;
        #1;
        expect_val(1'b0);
        compare("toggle_assert_a");
        @(posedge clk);
        async_in_rst = 1'b1;
        #1;
        expect_val(1'b0);
        compare("toggle_release_b");
        @(negedge clk);
        expect_val(1'b0);
        compare("toggle_before_c");
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_val(1'b1);
        compare("toggle_c_plus2");

        // pulse shorter than one clock period, entirely between edges
        #1;
        async_in_rst = 1'b0;
        #1;
        expect_val(1'b0);
        compare("short_pulse_assert");
        #2;
        async_in_rst = 1'b1;
        tick();
        expect_val(1'b0);
        compare("short_pulse_edge1");
        tick();
        expect_val(1'b1);
        compare("short_pulse_edge2");

        // table-driven stress and single-cycle pulse
        foreach (vec_q[i]) begin
            logic prev;
            prev         = async_in_rst;
            async_in_rst = vec_q[i].rst;
            if (prev && !vec_q[i].rst) begin
                #1;
                expect_val(1'b0);
                compare($sformatf("vec%0d_assert", i));
            end
            expect_val(vec_q[i].exp_out);
            tick();
            compare($sformatf("vec%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
